// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory handshake
// and loads the IF/ID register, with stall skid buffering and redirect flushing.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HELD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic [31:0] target_pc;

    assign target_pc = redirect_pc & 32'hFFFF_FFFC;

    // A redirect always wins; an outstanding unanswered request must still be
    // retired in DROP so its late response can be discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            pc         <= RESET_PC;
            skid_valid <= 1'b0;
            skid_instr <= 32'h0;
            skid_pc    <= 32'h0;
            ifid_valid <= 1'b0;
            ifid_instr <= 32'h0;
            ifid_pc    <= 32'h0;
            ifid_pc4   <= 32'h0;
        end else if (redirect) begin
            pc         <= target_pc;
            ifid_valid <= 1'b0;
            ifid_instr <= 32'h0;
            skid_valid <= 1'b0;
            skid_instr <= 32'h0;
            skid_pc    <= 32'h0;
            imem_req   <= 1'b1;
            if ((state == REQ || state == DROP) && !imem_ready) begin
                state <= DROP;
            end else begin
                state     <= REQ;
                imem_addr <= target_pc;
            end
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_ready) begin
                        pc <= imem_addr + 32'd4;
                        if (stall) begin
                            skid_valid <= 1'b1;
                            skid_instr <= imem_rdata;
                            skid_pc    <= imem_addr;
                            state      <= HELD;
                            imem_req   <= 1'b0;
                        end else begin
                            ifid_valid <= 1'b1;
                            ifid_instr <= imem_rdata;
                            ifid_pc    <= imem_addr;
                            ifid_pc4   <= imem_addr + 32'd4;
                            imem_addr  <= imem_addr + 32'd4;
                        end
                    end else if (!stall) begin
                        ifid_valid <= 1'b0;
                        ifid_instr <= 32'h0;
                    end
                end
                HELD: begin
                    if (!stall) begin
                        ifid_valid <= skid_valid;
                        ifid_instr <= skid_valid ? skid_instr : 32'h0;
                        ifid_pc    <= skid_pc;
                        ifid_pc4   <= skid_pc + 32'd4;
                        skid_valid <= 1'b0;
                        imem_addr  <= pc;
                        state      <= REQ;
                        imem_req   <= 1'b1;
                    end
                end
                DROP: begin
                    if (imem_ready) begin
                        imem_addr <= pc;
                        state     <= REQ;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
